// File: rtl/rf_path_sequencer.sv
// Break-before-make sequencer for the RF front-end pins.
// A mode change first drops the actives (mixer, LNAs) to their safe value,
// waits a guard time, moves the switch pins, waits a settle time, and only
// then re-enables the actives for the new mode. A debug level input lets
// the pins be driven directly; leaving debug replays a full sequence.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | pins at the applied mode, waiting for a request
// QUIESCE | actives safe, switches still at the old mode (guard time)
// SWITCH  | switches at the target, actives still safe (settle time)
// ENABLE  | one cycle: full target applied, done pulsed
module rf_path_sequencer #(
   parameter int GUARD_CYC  = 64,
   parameter int SETTLE_CYC = 256,
   parameter int CNT_W      = 16
) (
   input  logic       i_sys_clk,
   input  logic       i_rst_b,
   input  logic       i_req,
   input  logic [2:0] i_mode,
   input  logic       i_dbg_en,
   input  logic [7:0] i_dbg_pins,
   output logic [7:0] o_rf_pins,
   output logic [2:0] o_cur_mode,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_err
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_QUIESCE = 2'd1,
      ST_SWITCH  = 2'd2,
      ST_ENABLE  = 2'd3
   } state_t;

   localparam logic [2:0]       SAFE_ACT    = 3'b110;
   localparam logic [7:0]       RESET_PINS  = 8'h56;
   localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   // Invalid codes map to the low-power pattern; they never reach the table
   // because invalid requests are rejected before latching.
   function automatic logic [7:0] mode_pins(input logic [2:0] mode);
      logic [7:0] pins;
      case (mode)
         3'd0:    pins = 8'h56;
         3'd1:    pins = 8'h66;
         3'd2:    pins = 8'h9D;
         3'd3:    pins = 8'h5D;
         3'd4:    pins = 8'h6B;
         3'd5:    pins = 8'hAB;
         default: pins = 8'h56;
      endcase
      return pins;
   endfunction

   state_t           state_q, state_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic [2:0]       target_q, target_nxt;
   logic             pend_v_q, pend_v_nxt;
   logic [2:0]       pend_mode_q, pend_mode_nxt;
   logic             dbg_q;
   logic [7:0]       pins_nxt;
   logic [2:0]       cur_mode_nxt;
   logic             busy_nxt, done_nxt, err_nxt;
   logic             mode_ok, req_ok;
   logic [7:0]       target_pins;

   assign mode_ok     = (i_mode < 3'd6);
   assign req_ok      = i_req & mode_ok;
   assign target_pins = mode_pins(target_q);

   // Next-state, pending slot and registered-output computation.
   always_comb begin
      state_nxt     = state_q;
      cnt_nxt       = cnt_q;
      target_nxt    = target_q;
      pend_v_nxt    = pend_v_q;
      pend_mode_nxt = pend_mode_q;
      pins_nxt      = o_rf_pins;
      cur_mode_nxt  = o_cur_mode;
      done_nxt      = 1'b0;
      err_nxt       = i_req & ~mode_ok;

      if (i_dbg_en) begin
         state_nxt  = ST_IDLE;
         cnt_nxt    = '0;
         pend_v_nxt = 1'b0;
         pins_nxt   = i_dbg_pins;
      end else if (dbg_q) begin
         // Pins may be anything after debug, so always replay the full
         // sequence to the last applied mode.
         state_nxt  = ST_QUIESCE;
         cnt_nxt    = '0;
         target_nxt = o_cur_mode;
         pins_nxt   = {o_rf_pins[7:3], SAFE_ACT};
         if (req_ok && (i_mode != o_cur_mode)) begin
            pend_v_nxt    = 1'b1;
            pend_mode_nxt = i_mode;
         end
      end else begin
         // Requests arriving mid-sequence go to the one-deep pending slot;
         // a request for the in-flight target cancels anything pending.
         if ((state_q != ST_IDLE) && req_ok) begin
            pend_v_nxt    = (i_mode != target_q);
            pend_mode_nxt = i_mode;
         end

         case (state_q)
            ST_IDLE: begin
               if (req_ok) begin
                  if (i_mode == o_cur_mode) begin
                     done_nxt = 1'b1;
                  end else begin
                     state_nxt  = ST_QUIESCE;
                     cnt_nxt    = '0;
                     target_nxt = i_mode;
                     pins_nxt   = {o_rf_pins[7:3], SAFE_ACT};
                  end
               end
            end
            ST_QUIESCE: begin
               if (cnt_q == GUARD_LAST) begin
                  state_nxt = ST_SWITCH;
                  cnt_nxt   = '0;
                  pins_nxt  = {target_pins[7:3], SAFE_ACT};
               end else begin
                  cnt_nxt = cnt_q + CNT_W'(1);
               end
            end
            ST_SWITCH: begin
               if (cnt_q == SETTLE_LAST) begin
                  state_nxt    = ST_ENABLE;
                  cnt_nxt      = '0;
                  pins_nxt     = target_pins;
                  cur_mode_nxt = target_q;
               end else begin
                  cnt_nxt = cnt_q + CNT_W'(1);
               end
            end
            ST_ENABLE: begin
               cnt_nxt = '0;
               if (pend_v_nxt) begin
                  pend_v_nxt = 1'b0;
                  if (pend_mode_nxt == target_q) begin
                     state_nxt = ST_IDLE;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt  = ST_QUIESCE;
                     target_nxt = pend_mode_nxt;
                     pins_nxt   = {o_rf_pins[7:3], SAFE_ACT};
                  end
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end

      busy_nxt = (state_nxt != ST_IDLE);
      if (state_nxt == ST_ENABLE) begin
         done_nxt = 1'b1;
      end
   end

   // State, counter, pending slot and all outputs are registered together.
   always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         target_q    <= 3'd0;
         pend_v_q    <= 1'b0;
         pend_mode_q <= 3'd0;
         dbg_q       <= 1'b0;
         o_rf_pins   <= RESET_PINS;
         o_cur_mode  <= 3'd0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_err       <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         cnt_q       <= cnt_nxt;
         target_q    <= target_nxt;
         pend_v_q    <= pend_v_nxt;
         pend_mode_q <= pend_mode_nxt;
         dbg_q       <= i_dbg_en;
         o_rf_pins   <= pins_nxt;
         o_cur_mode  <= cur_mode_nxt;
         o_busy      <= busy_nxt;
         o_done      <= done_nxt;
         o_err       <= err_nxt;
      end
   end

endmodule

// File: tb/tb_rf_path_sequencer.sv
// Scoreboard bench for rf_path_sequencer with short guard/settle times.
// Stimulus pushes the expected pin-change / done / err events (with the
// cycle gap since the previous event where it is known); a monitor on the
// falling edge pops and compares each event the DUT produces.
module tb_rf_path_sequencer;

   localparam int K_ERR  = 0;
   localparam int K_PINS = 1;
   localparam int K_DONE = 2;

   typedef struct {
      string name;
      int    kind;
      int    data;
      int    gap;
   } ev_t;

   logic       clk;
   logic       rst_b;
   logic       req;
   logic [2:0] mode;
   logic       dbg_en;
   logic [7:0] dbg_pins;
   logic [7:0] rf_pins;
   logic [2:0] cur_mode;
   logic       busy, done, err;

   int   checks    = 0;
   int   failures  = 0;
   int   cyc       = 0;
   int   last_cyc  = 0;
   int   inv_viol  = 0;
   logic [7:0] prev_pins = 8'h56;
   logic       dbg_prev  = 1'b0;
   ev_t  exp_q[$];

   rf_path_sequencer #(
      .GUARD_CYC (4),
      .SETTLE_CYC(8),
      .CNT_W     (16)
   ) dut (
      .i_sys_clk (clk),
      .i_rst_b   (rst_b),
      .i_req     (req),
      .i_mode    (mode),
      .i_dbg_en  (dbg_en),
      .i_dbg_pins(dbg_pins),
      .o_rf_pins (rf_pins),
      .o_cur_mode(cur_mode),
      .o_busy    (busy),
      .o_done    (done),
      .o_err     (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic ex(input string name, input int kind, input int data, input int gap);
      ev_t e;
      e.name = name;
      e.kind = kind;
      e.data = data;
      e.gap  = gap;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input int data);
      ev_t e;
      int  gap;
      gap      = cyc - last_cyc;
      last_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_event: got kind=%0d data=%0h at cycle %0d, expected none", kind, data, cyc);
      end else begin
         e = exp_q.pop_front();
         if ((e.kind != kind) || (e.data != data) || ((e.gap >= 0) && (e.gap != gap))) begin
            failures++;
            $display("FAIL %s: got kind=%0d data=%0h gap=%0d expected kind=%0d data=%0h gap=%0d",
                     e.name, kind, data, gap, e.kind, e.data, e.gap);
         end
      end
   endtask

   // Monitor: turns DUT outputs into events and checks the actives invariant.
   always @(negedge clk) begin
      cyc++;
      if (err) observe(K_ERR, 0);
      if (rf_pins != prev_pins) begin
         observe(K_PINS, int'(rf_pins));
         prev_pins = rf_pins;
      end
      if (done) observe(K_DONE, int'(cur_mode));
      if (!dbg_en && !dbg_prev && (rf_pins[2:0] != 3'b110)) begin
         if (!(rf_pins inside {8'h9D, 8'h5D, 8'h6B, 8'hAB})) inv_viol++;
      end
      dbg_prev = dbg_en;
   end

   task automatic pulse_req(input logic [2:0] m);
      @(posedge clk); #1;
      req  = 1'b1;
      mode = m;
      @(posedge clk); #1;
      req  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (!busy) break;
      end
      chk(name, int'(busy), 0);
   endtask

   initial begin
      rst_b    = 1'b1;
      req      = 1'b0;
      mode     = 3'd0;
      dbg_en   = 1'b0;
      dbg_pins = 8'h00;
      #2 rst_b = 1'b0;
      #1;
      chk("reset_pins", int'(rf_pins), 'h56);
      chk("reset_cur_mode", int'(cur_mode), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_err", int'(err), 0);
      #19 rst_b = 1'b1;
      idle(2);

      // 1: low_power -> rx_lpf
      ex("t1_quiesce_to_switch", K_PINS, 'h9E, -1);
      ex("t1_enable_pins", K_PINS, 'h9D, 8);
      ex("t1_done", K_DONE, 2, 0);
      pulse_req(3'd2);
      chk("t1_quiesce_pins", int'(rf_pins), 'h56);
      chk("t1_busy", int'(busy), 1);
      wait_idle("t1_timeout");
      chk("t1_cur_mode", int'(cur_mode), 2);
      idle(2);

      // 2: rx_lpf -> tx_hpf
      ex("t2_quiesce", K_PINS, 'h9E, -1);
      ex("t2_switch", K_PINS, 'hAE, 4);
      ex("t2_enable", K_PINS, 'hAB, 8);
      ex("t2_done", K_DONE, 5, 0);
      pulse_req(3'd5);
      wait_idle("t2_timeout");
      chk("t2_cur_mode", int'(cur_mode), 5);
      idle(2);

      // 3: busy toward rx_hpf, then tx_lpf and tx_hpf requested; latest wins
      ex("t3_quiesce", K_PINS, 'hAE, -1);
      ex("t3_switch", K_PINS, 'h5E, 4);
      ex("t3_enable", K_PINS, 'h5D, 8);
      ex("t3_done", K_DONE, 3, 0);
      ex("t3_pend_quiesce", K_PINS, 'h5E, 1);
      ex("t3_pend_switch", K_PINS, 'hAE, 4);
      ex("t3_pend_enable", K_PINS, 'hAB, 8);
      ex("t3_pend_done", K_DONE, 5, 0);
      pulse_req(3'd3);
      pulse_req(3'd4);
      pulse_req(3'd5);
      chk("t3_busy", int'(busy), 1);
      wait_idle("t3_timeout");
      chk("t3_cur_mode", int'(cur_mode), 5);
      idle(2);

      // 4: invalid mode in IDLE, then while busy
      ex("t4_err_idle", K_ERR, 0, -1);
      pulse_req(3'd7);
      chk("t4_err_pulse", int'(err), 1);
      chk("t4_idle_busy", int'(busy), 0);
      @(posedge clk); #1;
      chk("t4_err_single", int'(err), 0);
      chk("t4_pins_held", int'(rf_pins), 'hAB);
      chk("t4_mode_held", int'(cur_mode), 5);
      idle(2);
      ex("t4_quiesce", K_PINS, 'hAE, -1);
      ex("t4_err_busy", K_ERR, 0, 2);
      ex("t4_switch", K_PINS, 'h56, 2);
      ex("t4_done", K_DONE, 0, 8);
      pulse_req(3'd0);
      pulse_req(3'd7);
      wait_idle("t4_timeout");
      chk("t4_cur_mode", int'(cur_mode), 0);
      idle(3);

      // 5: debug override mid-SWITCH, then exit replays the old mode
      ex("t5_switch", K_PINS, 'h5E, -1);
      ex("t5_dbg_pins", K_PINS, 'hFF, 4);
      ex("t5_exit_quiesce", K_PINS, 'hFE, 3);
      ex("t5_exit_switch", K_PINS, 'h56, 4);
      ex("t5_exit_done", K_DONE, 0, 8);
      pulse_req(3'd3);
      repeat (7) @(posedge clk);
      #1;
      dbg_en   = 1'b1;
      dbg_pins = 8'hFF;
      @(posedge clk); #1;
      chk("t5_dbg_pins_now", int'(rf_pins), 'hFF);
      chk("t5_dbg_busy", int'(busy), 0);
      chk("t5_dbg_cur_mode", int'(cur_mode), 0);
      repeat (2) @(posedge clk);
      #1;
      dbg_en = 1'b0;
      @(posedge clk); #1;
      chk("t5_exit_busy", int'(busy), 1);
      wait_idle("t5_timeout");
      chk("t5_cur_mode", int'(cur_mode), 0);
      idle(2);

      // 6: async reset mid-QUIESCE, then same-mode request
      ex("t6_pre_switch", K_PINS, 'h9E, -1);
      ex("t6_pre_enable", K_PINS, 'h9D, 8);
      ex("t6_pre_done", K_DONE, 2, 0);
      pulse_req(3'd2);
      wait_idle("t6_pre_timeout");
      idle(2);
      ex("t6_quiesce", K_PINS, 'h9E, -1);
      ex("t6_reset_pins", K_PINS, 'h56, -1);
      pulse_req(3'd4);
      @(posedge clk); #2;
      rst_b = 1'b0;
      #1;
      chk("t6_rst_pins", int'(rf_pins), 'h56);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_cur_mode", int'(cur_mode), 0);
      repeat (2) @(posedge clk);
      #3 rst_b = 1'b1;
      idle(2);
      ex("t6_same_done", K_DONE, 0, -1);
      pulse_req(3'd0);
      chk("t6_same_done_now", int'(done), 1);
      chk("t6_same_busy", int'(busy), 0);
      chk("t6_same_pins", int'(rf_pins), 'h56);
      @(posedge clk); #1;
      chk("t6_done_single", int'(done), 0);

      idle(4);
      chk("leftover_events", exp_q.size(), 0);
      chk("invariant_actives", inv_viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
